// File: rtl/nonogram_pkg.sv
// Shared constants, parser state encoding and byte classification for the
// board stream parser.
package nonogram_pkg;

  localparam logic [7:0] TOK_LINE   = 8'hFE;
  localparam logic [7:0] TOK_END    = 8'hFF;
  localparam logic [7:0] DATA_LIMIT = 8'h20;
  localparam int         CELL_W     = 12;
  localparam int         DATA_W     = CELL_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LHI,
    LLO,
    TOK,
    WLO,
    CSUM,
    ERR
  } parser_state_t;

  // A high byte below 0x20 carries the upper five bits of a 13-bit word.
  function automatic logic is_data(input logic [7:0] b);
    return b < DATA_LIMIT;
  endfunction

endpackage

// File: rtl/board_stream_parser_if.sv
// Byte-stream input and BRAM write bus of the board stream parser.
// master: the parser (consumes bytes, drives writes); slave: the surroundings.
interface board_stream_parser_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 13
) ();
  logic              axiiv;
  logic [7:0]        axiid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              line_start;

  modport master (
    input  axiiv, axiid,
    output wr_en, wr_addr, wr_data, line_start
  );

  modport slave (
    output axiiv, axiid,
    input  wr_en, wr_addr, wr_data, line_start
  );
endinterface

// File: rtl/board_stream_parser.sv
// Board stream parser: turns the received byte stream of one puzzle board into
// sequential 13-bit BRAM words (line headers and cell assignments).
// Optional macro BOARD_CHECKSUM_EN: expect an XOR checksum byte after 0xFF.
module board_stream_parser #(
  parameter int DATA_W = nonogram_pkg::DATA_W,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  board_stream_parser_if.master bus,
  output logic                 board_done,
  output logic [ADDR_W:0]      word_count,
  output logic                 err
);
  import nonogram_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH);

  parser_state_t     state_reg, state_next;
  logic [4:0]        hi_reg, hi_next;
  logic [ADDR_W:0]   word_count_reg, word_count_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              line_start_reg, line_start_next;
  logic              board_done_reg, board_done_next;
  logic              err_reg, err_next;
`ifdef BOARD_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  assign bus.wr_en      = wr_en_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.line_start = line_start_reg;
  assign board_done     = board_done_reg;
  assign word_count     = word_count_reg;
  assign err            = err_reg;

  // State and datapath registers; reset drops back to IDLE with quiet outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      hi_reg         <= '0;
      word_count_reg <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      line_start_reg <= 1'b0;
      board_done_reg <= 1'b0;
      err_reg        <= 1'b0;
`ifdef BOARD_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      hi_reg         <= hi_next;
      word_count_reg <= word_count_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      line_start_reg <= line_start_next;
      board_done_reg <= board_done_next;
      err_reg        <= err_next;
`ifdef BOARD_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  // Next-state decode; every transition happens only on a valid byte.
  always_comb begin
    state_next      = state_reg;
    hi_next         = hi_reg;
    word_count_next = word_count_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    line_start_next = 1'b0;
    board_done_next = 1'b0;
    err_next        = err_reg;
`ifdef BOARD_CHECKSUM_EN
    csum_next       = csum_reg;
    if (bus.axiiv && state_reg inside {LHI, LLO, TOK, WLO}) begin
      csum_next = csum_reg ^ bus.axiid;
    end
`endif
    if (bus.axiiv) begin
      case (state_reg)
        IDLE: begin
          if (bus.axiid == TOK_LINE) begin
            state_next      = LHI;
            err_next        = 1'b0;
            word_count_next = '0;
            wr_addr_next    = '0;
`ifdef BOARD_CHECKSUM_EN
            csum_next       = bus.axiid;
`endif
          end
        end
        LHI: begin
          if (is_data(bus.axiid)) begin
            hi_next    = bus.axiid[4:0];
            state_next = LLO;
          end else begin
            err_next   = 1'b1;
            state_next = ERR;
          end
        end
        LLO, WLO: begin
          // A full BRAM turns the would-be write into an error instead.
          if (word_count_reg == DEPTH_LIMIT) begin
            err_next   = 1'b1;
            state_next = ERR;
          end else begin
            wr_en_next      = 1'b1;
            wr_addr_next    = word_count_reg[ADDR_W-1:0];
            wr_data_next    = DATA_W'({hi_reg, bus.axiid});
            line_start_next = (state_reg == LLO);
            word_count_next = word_count_reg + 1'b1;
            state_next      = TOK;
          end
        end
        TOK: begin
          if (bus.axiid == TOK_LINE) begin
            state_next = LHI;
          end else if (bus.axiid == TOK_END) begin
            if (word_count_reg == '0) begin
              err_next   = 1'b1;
              state_next = ERR;
            end else begin
`ifdef BOARD_CHECKSUM_EN
              state_next      = CSUM;
`else
              board_done_next = 1'b1;
              state_next      = IDLE;
`endif
            end
          end else if (is_data(bus.axiid)) begin
            hi_next    = bus.axiid[4:0];
            state_next = WLO;
          end else begin
            err_next   = 1'b1;
            state_next = ERR;
          end
        end
        CSUM: begin
`ifdef BOARD_CHECKSUM_EN
          if (bus.axiid == csum_reg) begin
            board_done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
`endif
          state_next = IDLE;
        end
        ERR: begin
          if (bus.axiid == TOK_END) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_stream_parser.sv
// Directed, scoreboard-based bench for board_stream_parser. Two instances:
// the default depth and a DEPTH=4 copy for the overflow case.
module tb_board_stream_parser;

  typedef struct {
    logic [12:0] addr;
    logic [12:0] data;
    logic        ls;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_stream_parser_if #(.ADDR_W(13), .DATA_W(13)) bif ();
  board_stream_parser_if #(.ADDR_W(2),  .DATA_W(13)) bif4 ();

  logic        board_done, err, board_done4, err4;
  logic [13:0] word_count;
  logic [2:0]  word_count4;

  board_stream_parser #(.DATA_W(13), .DEPTH(8192), .ADDR_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif),
    .board_done(board_done), .word_count(word_count), .err(err)
  );

  board_stream_parser #(.DATA_W(13), .DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bif4),
    .board_done(board_done4), .word_count(word_count4), .err(err4)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t exp4_q[$];
  exp_t mon_e, mon4_e;
  int tgt = 0;
  logic       xor_active = 1'b0;
  logic [7:0] xor_acc = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [12:0] a, input logic [12:0] d, input logic ls);
    exp_t e;
    e.addr = a; e.data = d; e.ls = ls;
    if (tgt == 0) exp_q.push_back(e);
    else          exp4_q.push_back(e);
  endtask

  // Drive one byte at a falling edge; it is sampled at the next rising edge.
  task automatic send(input logic [7:0] b);
    if (tgt == 0) begin bif.axiiv = 1'b1; bif.axiid = b; end
    else          begin bif4.axiiv = 1'b1; bif4.axiid = b; end
    if (!xor_active && b == 8'hFE) begin
      xor_active = 1'b1;
      xor_acc = b;
    end else if (xor_active) begin
      xor_acc = xor_acc ^ b;
    end
    @(negedge clk);
    bif.axiiv = 1'b0;
    bif4.axiiv = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  // Closes a well-formed board on the main instance and checks the done pulse.
  task automatic finish_board(input string tag, input logic expect_done);
    send(8'hFF);
`ifdef BOARD_CHECKSUM_EN
    send(xor_acc);
`endif
    xor_active = 1'b0;
    check({tag, "_done"}, board_done, expect_done);
    idle_cycle();
    check({tag, "_done_clr"}, board_done, 1'b0);
  endtask

  task automatic send_first_board_body();
    push(13'd0, 13'h002, 1'b1);
    push(13'd1, 13'h005, 1'b0);
    push(13'd2, 13'h1007, 1'b0);
    send(8'hFE); send(8'h00); send(8'h02);
    check("t1_hdr_wr_en", bif.wr_en, 1'b1);
    check("t1_hdr_line_start", bif.line_start, 1'b1);
    send(8'h00); send(8'h05); send(8'h10); send(8'h07);
    check("t1_pre_end_done", board_done, 1'b0);
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (rst_n && bif.wr_en) begin
      check("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bif.wr_addr, mon_e.addr);
        check("wr_data", bif.wr_data, mon_e.data);
        check("line_start", bif.line_start, mon_e.ls);
      end
    end
  end

  // Scoreboard monitor for the DEPTH=4 instance.
  always @(negedge clk) begin
    if (rst_n && bif4.wr_en) begin
      check("wr4_expected", exp4_q.size() != 0, 1'b1);
      if (exp4_q.size() != 0) begin
        mon4_e = exp4_q.pop_front();
        check("wr4_addr", bif4.wr_addr, mon4_e.addr);
        check("wr4_data", bif4.wr_data, mon4_e.data);
        check("wr4_line_start", bif4.line_start, mon4_e.ls);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bif.axiiv = 1'b0;  bif.axiid = 8'h00;
    bif4.axiiv = 1'b0; bif4.axiid = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_wr_en", bif.wr_en, 1'b0);
    check("rst_wr_addr", bif.wr_addr, 13'd0);
    check("rst_wr_data", bif.wr_data, 13'd0);
    check("rst_line_start", bif.line_start, 1'b0);
    check("rst_board_done", board_done, 1'b0);
    check("rst_word_count", word_count, 14'd0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    idle_cycle();

    // Test 1: header plus two assignments
    tgt = 0;
    send_first_board_body();
    finish_board("t1", 1'b1);
    check("t1_word_count", word_count, 14'd3);
    check("t1_err", err, 1'b0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Test 2: two lines, headers only
    push(13'd0, 13'h001, 1'b1);
    push(13'd1, 13'h002, 1'b1);
    send(8'hFE); send(8'h00); send(8'h01);
    send(8'hFE); send(8'h00); send(8'h02);
    finish_board("t2", 1'b1);
    check("t2_word_count", word_count, 14'd2);
    check("t2_queue_empty", exp_q.size(), 0);

    // Test 3: illegal high byte, then recovery
    push(13'd0, 13'h001, 1'b1);
    send(8'hFE); send(8'h00); send(8'h01);
    send(8'h40);
    check("t3_err_set", err, 1'b1);
    send(8'hFF);
    xor_active = 1'b0;
    check("t3_no_done", board_done, 1'b0);
    check("t3_err_sticky", err, 1'b1);
    send(8'hFE);
    check("t3_err_cleared", err, 1'b0);
    check("t3_wc_cleared", word_count, 14'd0);
    push(13'd0, 13'h003, 1'b1);
    send(8'h00); send(8'h03);
    finish_board("t3", 1'b1);
    check("t3_queue_empty", exp_q.size(), 0);

    // Test 4: overflow on the DEPTH=4 instance
    tgt = 1;
    push(13'd0, 13'h000, 1'b1);
    push(13'd1, 13'h001, 1'b0);
    push(13'd2, 13'h002, 1'b0);
    push(13'd3, 13'h003, 1'b0);
    send(8'hFE); send(8'h00); send(8'h00);
    for (int i = 1; i <= 3; i++) begin
      send(8'h00);
      send(8'(i));
    end
    check("t4_err_before", err4, 1'b0);
    check("t4_wc_full", word_count4, 3'd4);
    send(8'h00); send(8'h04);
    check("t4_err_overflow", err4, 1'b1);
    check("t4_no_wr", bif4.wr_en, 1'b0);
    send(8'hFF);
    xor_active = 1'b0;
    check("t4_no_done", board_done4, 1'b0);
    check("t4_wc_final", word_count4, 3'd4);
    check("t4_queue_empty", exp4_q.size(), 0);
    tgt = 0;

    // Test 5: reset mid-board, then full resend
    push(13'd0, 13'h002, 1'b1);
    send(8'hFE); send(8'h00); send(8'h02); send(8'h00);
    rst_n = 1'b0;
    xor_active = 1'b0;
    #1;
    check("t5_rst_wr_en", bif.wr_en, 1'b0);
    check("t5_rst_wr_addr", bif.wr_addr, 13'd0);
    check("t5_rst_wr_data", bif.wr_data, 13'd0);
    check("t5_rst_word_count", word_count, 14'd0);
    check("t5_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    send_first_board_body();
    finish_board("t5", 1'b1);
    check("t5_word_count", word_count, 14'd3);
    check("t5_queue_empty", exp_q.size(), 0);

`ifdef BOARD_CHECKSUM_EN
    // Wrong checksum byte: error, no done
    send_first_board_body();
    send(8'hFF);
    send(xor_acc ^ 8'h01);
    xor_active = 1'b0;
    check("t6_bad_csum_done", board_done, 1'b0);
    check("t6_bad_csum_err", err, 1'b1);
    check("t6_queue_empty", exp_q.size(), 0);
`endif

    repeat (2) idle_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
